// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and
// default geometry of the attached FIFO.
package fifo_arbiter_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_ADDR_LEN = 3;

   // Controller state, also exported on state_o.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_arbiter_if.sv
// Bundle of the producer/consumer handshakes and FIFO control lines around
// the arbiter. The slave side is the arbiter itself; the master side is the
// surrounding pipeline (producers, consumer, and FIFO).
interface fifo_arbiter_if
   import fifo_arbiter_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int ADDR_LEN = DEF_ADDR_LEN
);

   logic                  enable_i;
   logic                  flush_i;
   logic [N-1:0]          req_valid_i;
   logic [N*WIDTH-1:0]    req_data_i;
   logic [N-1:0]          req_ready_o;
   logic                  pop_i;
   logic                  pop_valid_o;
   logic                  fifo_wr_o;
   logic [WIDTH-1:0]      fifo_data_o;
   logic                  fifo_rd_o;
   logic [ADDR_LEN:0]     count_o;
   logic                  full_o;
   logic                  empty_o;
   state_t                state_o;

   modport slave (
      input  enable_i, flush_i, req_valid_i, req_data_i, pop_i,
      output req_ready_o, pop_valid_o, fifo_wr_o, fifo_data_o, fifo_rd_o,
             count_o, full_o, empty_o, state_o
   );

   modport master (
      output enable_i, flush_i, req_valid_i, req_data_i, pop_i,
      input  req_ready_o, pop_valid_o, fifo_wr_o, fifo_data_o, fifo_rd_o,
             count_o, full_o, empty_o, state_o
   );

endinterface

// File: rtl/fifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: starting at ptr and wrapping modulo N,
// the first asserted request wins. Produces a one-hot grant plus its index.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_any
);

   localparam logic [PTR_W:0] N_C = (PTR_W+1)'(N);

   logic [PTR_W:0] pos_sum;

   // Scan N positions from ptr; one extra bit on pos_sum absorbs ptr+k < 2N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      pos_sum   = '0;
      for (int k = 0; k < N; k++) begin
         pos_sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (pos_sum >= N_C) begin
            pos_sum = pos_sum - N_C;
         end
         if (!grant_any && req[pos_sum[PTR_W-1:0]]) begin
            grant[pos_sum[PTR_W-1:0]] = 1'b1;
            grant_idx                 = pos_sum[PTR_W-1:0];
            grant_any                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin write-port arbiter and occupancy tracker for a shared FIFO.
// Grants are combinational from the request vector and registered state;
// occupancy is tracked locally so the FIFO is never overrun or underrun.
// A flush drains every stored entry without reporting any as valid.
module fifo_arbiter
   import fifo_arbiter_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_LEN = DEF_ADDR_LEN
) (
   input  logic           clk_i,
   input  logic           reset_i,
   fifo_arbiter_if.slave  bus
);

   localparam int               PTR_W   = (N > 1) ? $clog2(N) : 1;
   localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_C  = PTR_W'(N-1);

   state_t                       state_reg;
   logic                         pop_valid_reg;
   logic [PTR_W-1:0]             rr_ptr_reg;
   logic [PTR_W-1:0]             rr_ptr_next;
   logic [ADDR_LEN:0]            count_reg;
   logic [ADDR_LEN:0]            count_next;

   logic                         grant_en;
   logic [N-1:0]                 req_gated;
   logic [N-1:0]                 grant;
   logic [PTR_W-1:0]             grant_idx;
   logic                         grant_any;
   logic                         fifo_rd;
   logic [N-1:0][WIDTH-1:0]      data_masked;
   logic [WIDTH-1:0]             data_mux;

   // Grants only while running, not in the flush cycle, and never when full
   // (a same-cycle pop does not free a slot for the writer).
   assign grant_en  = (state_reg == ST_RUN) && !bus.flush_i && (count_reg < DEPTH_C);
   assign req_gated = bus.req_valid_i & {N{grant_en}};

   rr_arbiter #(
      .N     (N),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .req       (req_gated),
      .ptr       (rr_ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // AND-OR data mux keyed by the one-hot grant; yields zero with no grant.
   for (genvar gi = 0; gi < N; gi++) begin : g_data_mask
      assign data_masked[gi] = bus.req_data_i[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
   end

   // OR-reduce the masked request slices onto the FIFO write data.
   always_comb begin
      data_mux = '0;
      for (int k = 0; k < N; k++) begin
         data_mux = data_mux | data_masked[k];
      end
   end

   // Reads never hit an empty FIFO; during a flush the drain ignores pop_i.
   assign fifo_rd = (count_reg != '0) && ((state_reg == ST_FLUSH) || bus.pop_i);

   // Pointer moves past the winner only when a grant was made.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_any) begin
         rr_ptr_next = (grant_idx == LAST_C) ? '0 : grant_idx + 1'b1;
      end
   end

   // Occupancy follows write minus read; guards keep it within 0..DEPTH.
   always_comb begin
      count_next = count_reg;
      case ({grant_any, fifo_rd})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // Control FSM with its registered pop_valid output; flush wins over all.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg     <= ST_IDLE;
         pop_valid_reg <= 1'b0;
      end else begin
         pop_valid_reg <= fifo_rd && (state_reg != ST_FLUSH) && !bus.flush_i;
         if (bus.flush_i) begin
            state_reg <= ST_FLUSH;
         end else begin
            case (state_reg)
               ST_IDLE:  if (bus.enable_i)       state_reg <= ST_RUN;
               ST_RUN:   if (!bus.enable_i)      state_reg <= ST_IDLE;
               ST_FLUSH: if (count_reg == '0)    state_reg <= ST_IDLE;
               default:                          state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   // Round-robin pointer and occupancy counter.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign bus.req_ready_o = grant;
   assign bus.fifo_wr_o   = grant_any;
   assign bus.fifo_data_o = data_mux;
   assign bus.fifo_rd_o   = fifo_rd;
   assign bus.pop_valid_o = pop_valid_reg;
   assign bus.count_o     = count_reg;
   assign bus.full_o      = (count_reg == DEPTH_C);
   assign bus.empty_o     = (count_reg == '0);
   assign bus.state_o     = state_reg;

endmodule
